// File: rtl/spi_iccm_loader.sv
// spi_iccm_loader: buffers instruction words from the SPI receiver in a small
// FIFO, writes them to consecutive ICCM words over a req/gnt port, then
// releases the core reset once en_i is seen and all writes have drained.
//
// Optional feature macro: SPI_LOADER_CHECKSUM_EN adds checksum_o, a running
// modulo-2^DATA_WIDTH sum of every word granted to the ICCM.
//
// Handshake: a write transfers on every cycle where mem_req_o & mem_gnt_i.
// Once raised, mem_req_o stays high with mem_addr_o/mem_wdata_o stable until
// granted; it is never withdrawn except by reset.
//
// The word currently on the write port stays in the FIFO (as the head) until
// it is granted. An arriving word can be issued in the same cycle it is pushed
// when nothing older is waiting, giving a one-cycle rx_valid_i -> mem_req_o path.

module spi_iccm_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    ICCM_WORDS = 4096,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] rx_word_i,
    input  logic                  rx_valid_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    output logic                  system_rst_no,
    output logic                  load_done_o,
    output logic [ADDR_WIDTH-1:0] word_count_o,
`ifdef SPI_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum_o,
`endif
    output logic                  overflow_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] LP_MAX_IDX = ADDR_WIDTH'(ICCM_WORDS);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_ovf;

    logic                  w_fire;
    logic                  w_full;
    logic                  w_discard;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [ADDR_WIDTH-1:0] w_idx_next;
    logic [PW-1:0]         w_issue_ptr;
    logic                  w_head_avail;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_issue_data;
    logic                  w_req_next;
    logic [CW-1:0]         w_cnt_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    // Push/pop/issue decisions for this cycle.
    always_comb begin
        w_fire       = r_req & mem_gnt_i;
        w_full       = (r_count == CW'(FIFO_DEPTH));
        // Past the ICCM bound, queued words are thrown away one per cycle.
        w_discard    = !r_req && (r_count != '0) && (r_idx == LP_MAX_IDX);
        w_pop        = w_fire | w_discard;
        w_push       = rx_valid_i && (r_state == ST_LOAD) && (!w_full || w_pop);
        w_drop       = rx_valid_i && !w_push;
        w_idx_next   = r_idx + ADDR_WIDTH'(w_fire);
        // The in-flight word is the FIFO head, so the next candidate sits
        // one slot further on while a request is outstanding.
        w_issue_ptr  = r_rd_ptr + PW'(r_req);
        w_head_avail = (r_count > CW'(r_req));
        w_issue      = (!r_req || w_fire) && (w_head_avail || w_push) &&
                       (w_idx_next != LP_MAX_IDX);
        w_issue_data = w_head_avail ? r_mem[w_issue_ptr] : rx_word_i;
        w_req_next   = w_issue | (r_req & !w_fire);
        w_cnt_next   = r_count + CW'(w_push) - CW'(w_pop);
        w_addr_next  = BASE_ADDR + (w_idx_next << 2);
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_word_i;
        end
    end

    // FIFO pointers, write port registers, word index and overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_req    <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_cnt_next;
            r_req   <= w_req_next;
            if (w_issue) begin
                r_addr  <= w_addr_next;
                r_wdata <= w_issue_data;
            end
            if (w_fire) begin
                r_idx <= w_idx_next;
            end
            if (w_drop || w_discard) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Load sequencing: LOAD until en_i, DRAIN until nothing is left, then DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (en_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((w_cnt_next == '0) && !w_req_next) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

`ifdef SPI_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;

    // Running sum of granted words, held once loading is complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum <= '0;
        end else if (w_fire && (r_state != ST_DONE)) begin
            r_sum <= r_sum + r_wdata;
        end
    end

    assign checksum_o = r_sum;
`endif

    assign mem_req_o     = r_req;
    assign mem_we_o      = r_req;
    assign mem_be_o      = r_req ? 4'hF : 4'h0;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign system_rst_no = (r_state == ST_DONE);
    assign load_done_o   = (r_state == ST_DONE);
    assign word_count_o  = r_idx;
    assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_spi_iccm_loader.sv
// Directed bench for spi_iccm_loader with a small ICCM (4 words) so the
// capacity bound is reachable. Expected {address, data} pairs are queued as
// words are driven and checked against every granted write.

module tb_spi_iccm_loader;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic [DW-1:0] rx_word_i = '0;
  logic          rx_valid_i = 1'b0;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          system_rst_no;
  logic          load_done_o;
  logic [AW-1:0] word_count_o;
  logic          overflow_o;
`ifdef SPI_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  int xfer_base;

  spi_iccm_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (32'h0000_0000),
    .ICCM_WORDS(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .rx_word_i    (rx_word_i),
    .rx_valid_i   (rx_valid_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .system_rst_no(system_rst_no),
    .load_done_o  (load_done_o),
    .word_count_o (word_count_o),
`ifdef SPI_LOADER_CHECKSUM_EN
    .checksum_o   (checksum_o),
`endif
    .overflow_o   (overflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    en_i = 1'b0;
    rx_valid_i = 1'b0;
    rx_word_i = '0;
    mem_gnt_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_be", 64'(mem_be_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
    chk("rst_sysrst", 64'(system_rst_no), 64'd0);
    chk("rst_done", 64'(load_done_o), 64'd0);
    chk("rst_count", 64'(word_count_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
`ifdef SPI_LOADER_CHECKSUM_EN
    chk("rst_csum", 64'(checksum_o), 64'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
  endtask

  // driver: present one word for one cycle and queue its expected write
  task automatic send(input logic [DW-1:0] w, input logic [AW-1:0] exp_addr, input bit expect_write);
    rx_word_i = w;
    rx_valid_i = 1'b1;
    if (expect_write) exp_q.push_back({exp_addr, w});
    step();
    rx_valid_i = 1'b0;
  endtask

  // scoreboard: every granted write must match the head of the expected queue
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o && mem_gnt_i) begin
      n_xfer++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL xfer_unexpected: observed addr %0h data %0h, required no write", mem_addr_o, mem_wdata_o);
      end
      if (exp_q.size() != 0) chk("xfer_addr_data", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
      chk("xfer_we", 64'(mem_we_o), 64'd1);
      chk("xfer_be", 64'(mem_be_o), 64'hF);
    end
  end

  initial begin
    // 1: three words, grant tied high, en_i with the last word
    do_reset();
    mem_gnt_i = 1'b1;
    rx_word_i = 32'h0000_0093; rx_valid_i = 1'b1; exp_q.push_back({32'h0, 32'h0000_0093});
    step();
    rx_word_i = 32'h0010_0113; exp_q.push_back({32'h4, 32'h0010_0113});
    step();
    rx_word_i = 32'h0000_006F; en_i = 1'b1; exp_q.push_back({32'h8, 32'h0000_006F});
    step();
    rx_valid_i = 1'b0;
    #3;
    chk("t1_req_last", 64'(mem_req_o), 64'd1);
    chk("t1_sysrst_pre", 64'(system_rst_no), 64'd0);
    step();
    #3;
    chk("t1_sysrst", 64'(system_rst_no), 64'd1);
    chk("t1_done", 64'(load_done_o), 64'd1);
    chk("t1_req_done", 64'(mem_req_o), 64'd0);
    chk("t1_count", 64'(word_count_o), 64'd3);
    chk("t1_ovf", 64'(overflow_o), 64'd0);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    en_i = 1'b0;
    step(); step();
    #3;
    chk("t1_done_sticky", 64'(system_rst_no), 64'd1);

    // 2: held request under a withheld grant
    do_reset();
    xfer_base = n_xfer;
    send(32'hDEAD_BEEF, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t2_req_hold", 64'(mem_req_o), 64'd1);
      chk("t2_addr_hold", 64'(mem_addr_o), 64'd0);
      chk("t2_data_hold", 64'(mem_wdata_o), 64'hDEAD_BEEF);
      step();
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    step();
    #3;
    chk("t2_one_xfer", 64'(n_xfer - xfer_base), 64'd1);
    chk("t2_req_off", 64'(mem_req_o), 64'd0);
    chk("t2_count", 64'(word_count_o), 64'd1);

    // 3: FIFO overflow with grant low
    do_reset();
    xfer_base = n_xfer;
    for (int i = 0; i < 5; i++) begin
      send(32'hA000_0000 + 32'(i), 32'(4 * i), i < 4);
    end
    #3;
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    chk("t3_req", 64'(mem_req_o), 64'd1);
    step();
    mem_gnt_i = 1'b1;
    repeat (6) step();
    #3;
    chk("t3_four_xfers", 64'(n_xfer - xfer_base), 64'd4);
    chk("t3_count", 64'(word_count_o), 64'd4);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // 4: ICCM bound (4 words), six words with grant high
    do_reset();
    xfer_base = n_xfer;
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(32'hB000_0000 + 32'(i), 32'(4 * i), i < 4);
    end
    repeat (4) step();
    #3;
    chk("t4_xfers", 64'(n_xfer - xfer_base), 64'd4);
    chk("t4_count_sat", 64'(word_count_o), 64'd4);
    chk("t4_ovf", 64'(overflow_o), 64'd1);
    chk("t4_req_off", 64'(mem_req_o), 64'd0);

    // 5: reset during a pending request, then during DONE
    do_reset();
    send(32'h1234_5678, 32'h0, 1'b1);
    #3;
    chk("t5_req_pending", 64'(mem_req_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("t5_req_async", 64'(mem_req_o), 64'd0);
    chk("t5_sysrst_async", 64'(system_rst_no), 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    mem_gnt_i = 1'b1;
    send(32'h0000_0013, 32'h0, 1'b1);
    en_i = 1'b1;
    repeat (3) step();
    #3;
    chk("t5_done", 64'(system_rst_no), 64'd1);
    chk("t5_count", 64'(word_count_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("t5_sysrst_drop", 64'(system_rst_no), 64'd0);
    chk("t5_done_drop", 64'(load_done_o), 64'd0);

    // 6: random grant pattern, four words, then drain
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = 1'($urandom_range(0, 1));
      send($urandom(), 32'(4 * i), 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      mem_gnt_i = 1'($urandom_range(0, 1));
      step();
    end
    mem_gnt_i = 1'b1;
    repeat (5) step();
    en_i = 1'b1;
    repeat (3) step();
    #3;
    chk("t6_done", 64'(load_done_o), 64'd1);
    chk("t6_count", 64'(word_count_o), 64'd4);
    chk("t6_ovf", 64'(overflow_o), 64'd0);
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
    en_i = 1'b0;

`ifdef SPI_LOADER_CHECKSUM_EN
    // 7: checksum wraps modulo 2^32
    do_reset();
    mem_gnt_i = 1'b1;
    send(32'hFFFF_FFFF, 32'h0, 1'b1);
    send(32'h0000_0002, 32'h4, 1'b1);
    repeat (3) step();
    #3;
    chk("t7_csum", 64'(checksum_o), 64'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_iccm_loader.md
Name: spi_iccm_loader

Overview:
- Sits directly downstream of the SPI slave receiver in the SoC.
- Takes each assembled 32-bit instruction word (one-cycle valid pulse) and buffers it in a small FIFO.
- Writes the words to consecutive ICCM locations through a simple req/gnt write port.
- When en_i is raised, drains any outstanding writes, then releases the core/system reset.

Parameters:
- DATA_WIDTH, 32, width of received word and memory write data.
- ADDR_WIDTH, 32, width of memory byte address.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- ICCM_WORDS, 4096, capacity of the ICCM in words; last legal index is ICCM_WORDS-1.
- FIFO_DEPTH, 4, receive buffer depth in words; must be a power of two and at least 2.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- en_i  input  1  load-complete / core-enable request from top level; level-sensitive
- rx_word_i  input  DATA_WIDTH  word from the SPI receiver
- rx_valid_i  input  1  one-cycle pulse; rx_word_i is valid in this cycle
- mem_req_o  output  1  ICCM write request
- mem_we_o  output  1  write enable; equals mem_req_o
- mem_be_o  output  4  byte enables; 4'hF whenever mem_req_o=1, else 0
- mem_addr_o  output  ADDR_WIDTH  byte address of the write
- mem_wdata_o  output  DATA_WIDTH  write data
- mem_gnt_i  input  1  grant; a transfer completes on any cycle with mem_req_o & mem_gnt_i
- system_rst_no  output  1  active-low reset to the core; 0 until load is DONE
- load_done_o  output  1  high in DONE
- word_count_o  output  ADDR_WIDTH  number of words written to ICCM
- overflow_o  output  1  sticky error flag
- checksum_o  output  DATA_WIDTH  running checksum (present only with the optional feature)

Behaviour:
- Reset (async, rst_ni=0):
  - State LOAD; FIFO empty; write index = 0.
  - Outputs: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, system_rst_no=0, load_done_o=0, word_count_o=0, overflow_o=0, checksum_o=0.
- Clocking: all state updates on posedge clk_i.
- FIFO push:
  - rx_valid_i=1, FIFO not full, state LOAD: push rx_word_i.
  - rx_valid_i=1 with FIFO full: drop the word and set overflow_o.
  - rx_valid_i=1 in DRAIN or DONE: drop the word and set overflow_o.
  - A push and a pop in the same cycle are allowed while the FIFO is full; the FIFO stays full and the incoming word is accepted.
- Write port:
  - When the FIFO is non-empty and no request is pending, load the head word into the output registers and assert mem_req_o on the next cycle.
  - Minimum latency from rx_valid_i to mem_req_o is 1 cycle.
  - While mem_req_o=1 and mem_gnt_i=0, hold mem_addr_o and mem_wdata_o stable; the request is never withdrawn.
  - On a cycle with req&gnt:
    - pop the FIFO;
    - increment the write index and word_count_o;
    - if the FIFO still holds data, the next request may be issued in the following cycle (back-to-back, one word per cycle at gnt=1).
  - mem_addr_o = BASE_ADDR + 4*index. Address arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
- ICCM bound: when index reaches ICCM_WORDS:
  - further popped words are discarded without issuing mem_req_o;
  - overflow_o is set;
  - index and word_count_o saturate.
- State machine:
  - LOAD: accept words and issue writes. When en_i=1, go to DRAIN.
  - DRAIN: stop accepting words; finish the FIFO contents and any pending request. When the FIFO is empty and no request is pending, go to DONE.
  - DONE: system_rst_no=1, load_done_o=1, mem_req_o=0. Leave DONE only on reset. en_i falling in DONE has no effect.
- en_i rising in the same cycle as rx_valid_i: the word is accepted; the state then goes to DRAIN.
- Reset mid-transfer: any pending request is abandoned immediately (mem_req_o=0 asynchronously) and system_rst_no returns to 0.

Optional Feature:
- Macro: SPI_LOADER_CHECKSUM_EN.
- Defined:
  - checksum_o = modulo-2^DATA_WIDTH sum of every word actually written to ICCM (on req&gnt).
  - Cleared by reset; frozen in DONE.
- Not defined: the checksum_o port and its adder are absent.

Test Plan:
- Push 3 words 0x00000093, 0x00100113, 0x0000006F, with mem_gnt_i tied 1, then en_i=1 → writes to addresses 0x0, 0x4, 0x8 with matching data; word_count_o=3; system_rst_no rises 1 cycle after the last grant; overflow_o=0.
- Push word 0xDEADBEEF with mem_gnt_i held 0 for 5 cycles → mem_req_o=1 and address/data held stable for all 5 cycles; exactly one transfer on the grant cycle.
- FIFO_DEPTH=4, mem_gnt_i=0, push 5 words → first 4 retained, 5th dropped, overflow_o=1; after grant, exactly 4 writes.
- ICCM_WORDS=2, push 3 words with gnt=1 → writes at 0x0 and 0x4 only; overflow_o=1; word_count_o=2.
- Assert rst_ni=0 during a pending request → mem_req_o=0 and system_rst_no=0 immediately; after release, the next word writes to BASE_ADDR.
- With SPI_LOADER_CHECKSUM_EN: words 0xFFFFFFFF and 0x00000002 written → checksum_o=0x00000001.
